return_address_stack: RTL

- Hardware return-address stack. It is the consumer side of the jump-and-link path.
- JAL pushes its link address (PC+4) at the same moment the link register write is selected.
- JR $ra pops it, giving fetch a predicted return target.
- Sits beside the PC logic in the MIPS single-cycle datapath and is driven by control-unit decode strobes.

---
 rtl/mips_ras_pkg.sv | 14 +
 rtl/ras_storage.sv | 32 +++
 rtl/return_address_stack.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mips_ras_pkg.sv
// Shared constants and types for the return-address stack.
package mips_ras_pkg;

  localparam int unsigned RAS_DEPTH_DEF = 8;
  localparam int unsigned RAS_NBITS_DEF = 32;
  localparam int unsigned STAT_BITS     = 16;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_OVERFLOW,
    EV_UNDERFLOW
  } ras_event_e;

endpackage

// File: rtl/ras_storage.sv
// Depth x NBits register array: one synchronous write port, one combinational
// read port, asynchronous active-low clear.
module ras_storage #(
  parameter int unsigned Depth = 8,
  parameter int unsigned NBits = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(Depth)-1:0] widx,
  input  logic [NBits-1:0]         wdata,
  input  logic [$clog2(Depth)-1:0] ridx,
  output logic [NBits-1:0]         rdata
);

  logic [NBits-1:0] mem [Depth];

  // Entry array; cleared on reset, single write per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Depth); i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  // Combinational read of the selected entry.
  assign rdata = mem[ridx];

endmodule

// File: rtl/return_address_stack.sv
// Return-address stack: JAL pushes the link address, JR $ra pops the
// predicted return target. Circular buffer, oldest entry overwritten on
// overflow.
// Optional build macro RAS_STATS_EN enables saturating overflow/underflow
// event counters; without it both counter ports are tied to zero.
module return_address_stack
  import mips_ras_pkg::*;
#(
  parameter int unsigned NBits = RAS_NBITS_DEF,
  parameter int unsigned Depth = RAS_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Push,
  input  logic [NBits-1:0]     PushAddr,
  input  logic                 Pop,
  output logic [NBits-1:0]     TopAddr,
  output logic                 Valid,
  output logic                 Full,
  output logic                 Underflow,
  output logic [STAT_BITS-1:0] OverflowCount,
  output logic [STAT_BITS-1:0] UnderflowCount
);

  localparam int unsigned PtrBits = $clog2(Depth);
  localparam int unsigned CntBits = PtrBits + 1;
  localparam logic [CntBits-1:0] FullCnt = CntBits'(Depth);

  logic [PtrBits-1:0] tp_q, tp_d;
  logic [CntBits-1:0] count_q, count_d;
  logic               we;
  logic [PtrBits-1:0] widx;
  logic [NBits-1:0]   rdata;
  ras_event_e         ev;
  logic               underflow_q;

  ras_storage #(
    .Depth (Depth),
    .NBits (NBits)
  ) u_storage (
    .clk   (clk),
    .rst_n (reset),
    .we    (we),
    .widx  (widx),
    .wdata (PushAddr),
    .ridx  (tp_q),
    .rdata (rdata)
  );

  // Next pointer/count, write control and event classification.
  always_comb begin
    tp_d    = tp_q;
    count_d = count_q;
    we      = 1'b0;
    widx    = tp_q + PtrBits'(1);
    ev      = EV_NONE;
    if (Push && Pop && (count_q != '0)) begin
      // Replace the top in place.
      we   = 1'b1;
      widx = tp_q;
    end else if (Push) begin
      // Plain push, or push+pop on an empty stack.
      we   = 1'b1;
      tp_d = tp_q + PtrBits'(1);
      if (count_q == FullCnt) begin
        ev = EV_OVERFLOW;
      end else begin
        count_d = count_q + CntBits'(1);
      end
    end else if (Pop) begin
      if (count_q != '0) begin
        tp_d    = tp_q - PtrBits'(1);
        count_d = count_q - CntBits'(1);
      end else begin
        ev = EV_UNDERFLOW;
      end
    end
  end

  // Pointer, occupancy and underflow pulse registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tp_q        <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      tp_q        <= tp_d;
      count_q     <= count_d;
      underflow_q <= (ev == EV_UNDERFLOW);
    end
  end

  assign TopAddr   = (count_q != '0) ? rdata : '0;
  assign Valid     = (count_q != '0);
  assign Full      = (count_q == FullCnt);
  assign Underflow = underflow_q;

`ifdef RAS_STATS_EN
  logic [STAT_BITS-1:0] ovf_cnt_q;
  logic [STAT_BITS-1:0] unf_cnt_q;

  // Saturating event counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_cnt_q <= '0;
      unf_cnt_q <= '0;
    end else begin
      if ((ev == EV_OVERFLOW) && (ovf_cnt_q != '1)) begin
        ovf_cnt_q <= ovf_cnt_q + STAT_BITS'(1);
      end
      if ((ev == EV_UNDERFLOW) && (unf_cnt_q != '1)) begin
        unf_cnt_q <= unf_cnt_q + STAT_BITS'(1);
      end
    end
  end

  assign OverflowCount  = ovf_cnt_q;
  assign UnderflowCount = unf_cnt_q;
`else
  assign OverflowCount  = '0;
  assign UnderflowCount = '0;
`endif

endmodule
